// File: rtl/ft_toggle_arb.sv
// Four-requester round-robin arbiter guarding a WIDTH-bit bank of T flip-flops with preset.
// Each granted operation takes two cycles: IDLE picks the winner, GRANT acks it and the bank updates on leaving GRANT.
module ft_toggle_arb #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic               CP,
    input  logic               CD,
    input  logic [3:0]         req,
    input  logic [3:0]         op,
    input  logic [4*WIDTH-1:0] mask,
    output logic [3:0]         ack,
    output logic               busy,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   QN,
    output logic [7:0]         op_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       ptr;
    logic [1:0]       sel;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             op_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] q;

    // Round-robin search from ptr upward with wrap; descending loop lets the nearest requester win.
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    always_ff @(posedge CP or posedge CD) begin
        if (CD) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Unknown encodings fall back to IDLE.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = (|req) ? GRANT : IDLE;
            GRANT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CP or posedge CD) begin
        if (CD) begin
            ptr      <= 2'd0;
            sel      <= 2'd0;
            op_reg   <= 1'b0;
            mask_reg <= '0;
            q        <= PRESET_VAL;
            op_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel      <= win;
                        op_reg   <= op[win];
                        mask_reg <= mask[int'(win)*WIDTH +: WIDTH];
                    end
                end
                GRANT: begin
                    q      <= op_reg ? (q | mask_reg) : (q ^ mask_reg);
                    ptr    <= sel + 2'd1;
                    op_cnt <= op_cnt + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Ack derives from the state register, so an async reset in GRANT drops it at once.
    always_comb begin
        ack = 4'b0000;
        if (state == GRANT) begin
            ack[sel] = 1'b1;
        end
    end

    assign busy = (state == GRANT);
    assign Q    = q;
    assign QN   = ~q;

endmodule

// File: tb/tb_ft_toggle_arb.sv
// Directed bench for ft_toggle_arb: reset, single toggle, round-robin order, preset, mid-grant reset, counter wrap.
module tb_ft_toggle_arb;

    localparam int WIDTH = 8;

    logic               CP;
    logic               CD;
    logic [3:0]         req;
    logic [3:0]         op;
    logic [4*WIDTH-1:0] mask;
    logic [3:0]         ack;
    logic               busy;
    logic [WIDTH-1:0]   Q;
    logic [WIDTH-1:0]   QN;
    logic [7:0]         op_cnt;

    int errors;
    int checks;

    ft_toggle_arb #(.WIDTH(WIDTH), .PRESET_VAL(8'hFF)) dut (
        .CP(CP), .CD(CD), .req(req), .op(op), .mask(mask),
        .ack(ack), .busy(busy), .Q(Q), .QN(QN), .op_cnt(op_cnt)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic wait_cycle();
        @(posedge CP);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge CP);
        CD = 1'b1;
        #2;
        check_output("rst_q", 32'(Q), 32'hFF);
        check_output("rst_qn", 32'(QN), 32'h00);
        check_output("rst_ack", 32'(ack), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_cnt", 32'(op_cnt), 32'h0);
        @(negedge CP);
        CD = 1'b0;
    endtask

    logic [7:0] exp_q;

    initial begin
        errors = 0;
        checks = 0;
        CD     = 1'b0;
        req    = 4'b0000;
        op     = 4'b0000;
        mask   = '0;
        #2;
        apply_reset();

        // Idle after reset: nothing moves.
        for (int i = 0; i < 10; i++) begin
            wait_cycle();
            check_output("idle_ack", 32'(ack), 32'h0);
            check_output("idle_q", 32'(Q), 32'hFF);
        end
        check_output("idle_qn", 32'(QN), 32'h00);
        check_output("idle_cnt", 32'(op_cnt), 32'h0);

        // Single toggle; operands changed during GRANT must not matter.
        req  = 4'b0001;
        op   = 4'b0000;
        mask = {8'h00, 8'h00, 8'h00, 8'h0F};
        wait_cycle();
        check_output("tog_ack", 32'(ack), 32'h1);
        check_output("tog_busy", 32'(busy), 32'h1);
        check_output("tog_q_early", 32'(Q), 32'hFF);
        req  = 4'b0000;
        op   = 4'b0001;
        mask = {8'h00, 8'h00, 8'h00, 8'hFF};
        wait_cycle();
        check_output("tog_q", 32'(Q), 32'hF0);
        check_output("tog_qn", 32'(QN), 32'h0F);
        check_output("tog_cnt", 32'(op_cnt), 32'h1);
        check_output("tog_ack_off", 32'(ack), 32'h0);
        check_output("tog_busy_off", 32'(busy), 32'h0);

        // Round-robin fairness from a fresh pointer.
        apply_reset();
        req   = 4'b1111;
        op    = 4'b0000;
        mask  = {8'h01, 8'h01, 8'h01, 8'h01};
        exp_q = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            wait_cycle();
            check_output($sformatf("rr_ack%0d", i), 32'(ack), 32'(4'b0001 << (i % 4)));
            wait_cycle();
            exp_q = exp_q ^ 8'h01;
            check_output($sformatf("rr_q%0d", i), 32'(Q), 32'(exp_q));
        end
        req = 4'b0000;
        check_output("rr_cnt", 32'(op_cnt), 32'd8);

        // Clear via requester 1, then preset via requester 2.
        req  = 4'b0010;
        op   = 4'b0000;
        mask = {8'h00, 8'h00, 8'hFF, 8'h00};
        wait_cycle();
        check_output("clr_ack", 32'(ack), 32'h2);
        req = 4'b0000;
        wait_cycle();
        check_output("clr_q", 32'(Q), 32'h00);
        req  = 4'b0100;
        op   = 4'b0100;
        mask = {8'h00, 8'hA5, 8'h00, 8'h00};
        wait_cycle();
        check_output("pre_ack", 32'(ack), 32'h4);
        req = 4'b0000;
        wait_cycle();
        check_output("pre_q", 32'(Q), 32'hA5);
        check_output("pre_qn", 32'(QN), 32'h5A);
        check_output("pre_cnt", 32'(op_cnt), 32'd10);

        // Reset during GRANT aborts the op; pointer (was 3) must restart at 0.
        req  = 4'b0001;
        op   = 4'b0000;
        mask = {8'h00, 8'h00, 8'h00, 8'hFF};
        wait_cycle();
        check_output("ab_ack_pre", 32'(ack), 32'h1);
        #2;
        CD = 1'b1;
        #1;
        check_output("ab_ack", 32'(ack), 32'h0);
        check_output("ab_busy", 32'(busy), 32'h0);
        check_output("ab_q", 32'(Q), 32'hFF);
        check_output("ab_cnt", 32'(op_cnt), 32'h0);
        @(negedge CP);
        CD   = 1'b0;
        req  = 4'b1111;
        mask = {8'h08, 8'h04, 8'h02, 8'h01};
        wait_cycle();
        check_output("ab_next_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        wait_cycle();
        check_output("ab_next_q", 32'(Q), 32'hFE);
        check_output("ab_next_cnt", 32'(op_cnt), 32'h1);

        // Counter wrap with zero-mask ops.
        apply_reset();
        req  = 4'b0001;
        op   = 4'b0000;
        mask = '0;
        for (int i = 0; i < 255; i++) begin
            wait_cycle();
            wait_cycle();
        end
        check_output("wrap_cnt255", 32'(op_cnt), 32'd255);
        wait_cycle();
        check_output("wrap_ack", 32'(ack), 32'h1);
        req = 4'b0000;
        wait_cycle();
        check_output("wrap_cnt0", 32'(op_cnt), 32'd0);
        check_output("wrap_q", 32'(Q), 32'hFF);
        wait_cycle();
        check_output("wrap_idle_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ft_toggle_arb.md
FT_TOGGLE_ARB -- requirements
Module: ft_toggle_arb

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the toggle register bank.
REQ-002 Parameter PRESET_VAL, default 8'hFF (WIDTH bits), bank value loaded on reset.
REQ-003 CP  input  1  clock; all state changes on rising edge.
REQ-004 CD  input  1  reset; asynchronous, active-high.
REQ-005 req  input  4  per-requester request; requester i = bit i.
REQ-006 op  input  4  per-requester opcode; 0 = toggle, 1 = preset.
REQ-007 mask  input  4*WIDTH  per-requester bit mask; requester i uses bits [i*WIDTH +: WIDTH].
REQ-008 ack  output  4  one-hot grant/acknowledge pulse.
REQ-009 busy  output  1  high when the FSM is not in IDLE.
REQ-010 Q  output  WIDTH  bank state.
REQ-011 QN  output  WIDTH  bitwise inverse of Q at all times.
REQ-012 op_cnt  output  8  count of completed operations.

Function
REQ-013 The block SHALL arbitrate four requesters for shared access to one WIDTH-bit bank of T flip-flops with preset.
REQ-014 FSM states: IDLE, GRANT; any other encoding SHALL return to IDLE on the next edge.
REQ-015 IDLE: if req != 0, winner selected round-robin; search starts at ptr, wraps 3->0; winner's op and mask registered; next state GRANT.
REQ-016 IDLE with req == 0: remain IDLE; no bank, ptr or op_cnt change.
REQ-017 GRANT: ack[sel] = 1 for exactly this one cycle, all other ack bits 0; next state IDLE unconditionally.
REQ-018 At the GRANT->IDLE edge the bank updates: toggle op Q <= Q ^ mask; preset op Q <= Q | mask.
REQ-019 At that same edge, ptr <= (sel+1) mod 4 and op_cnt <= op_cnt + 1, wrapping 255 -> 0.
REQ-020 Latency: req seen in IDLE in cycle n -> ack high in cycle n+1 -> new Q visible in cycle n+2.
REQ-021 Maximum throughput: one operation every 2 cycles.
REQ-022 Requester SHALL hold req, op and mask stable until ack is seen; values are sampled only in IDLE.
REQ-023 A requester holding req high after its ack is treated as a new request at the next IDLE cycle, subject to round-robin.
REQ-024 Changes to req during GRANT SHALL NOT affect the current operation.
REQ-025 Zero mask is legal: the op completes and is acked, Q is unchanged, and op_cnt increments.
REQ-026 busy SHALL be high exactly in GRANT.

Reset
REQ-027 While CD = 1, independent of CP, outputs SHALL be: Q = PRESET_VAL, QN = ~PRESET_VAL, ack = 0, busy = 0, op_cnt = 0.
REQ-028 While CD = 1, internal state SHALL be: state = IDLE, ptr = 0, registered op/mask = 0.
REQ-029 CD asserted during GRANT SHALL abort the operation: no bank update, no op_cnt increment, and ack drops immediately.
REQ-030 The first arbitration SHALL occur on the first rising CP edge after CD is released.

Verification
REQ-031 Reset then idle: CD pulse, req = 0 for 10 cycles -> Q = 8'hFF, QN = 8'h00, op_cnt = 0, ack = 0 throughout.
REQ-032 Single toggle: req = 4'b0001, op = 0, mask0 = 8'h0F -> ack = 4'b0001 one cycle later; Q = 8'hF0 the cycle after; op_cnt = 1.
REQ-033 Round-robin fairness: req = 4'b1111 held for 8 ops, all toggle with mask 8'h01 -> ack order 0,1,2,3,0,1,2,3; Q toggles bit 0 each op; op_cnt = 8.
REQ-034 Preset after clear: from Q = 8'h00, requester 2 issues preset with mask 8'hA5 -> ack = 4'b0100, Q = 8'hA5, QN = 8'h5A.
REQ-035 Reset mid-operation: assert CD during a GRANT cycle with mask 8'hFF -> ack falls asynchronously; Q = 8'hFF, op_cnt = 0; the next arbitration starts from requester 0.
REQ-036 Counter wrap: 256 zero-mask ops -> op_cnt returns to 0, Q is unchanged.
